// File: rtl/arb_rr_pkt_stream_if.sv
// Stream bundle shared by N packet requesters, the round-robin arbiter and the sink.
// Defining ARB_WEIGHT_EN adds the per-requester 4-bit weight inputs.
interface arb_rr_pkt_stream_if #(
    parameter int N  = 4,
    parameter int DW = 16
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  i_valid;
    logic [N-1:0]  i_last;
    logic [DW-1:0] i_data [N];
    logic [N-1:0]  o_ready;
    logic          o_valid;
    logic          o_last;
    logic [DW-1:0] o_data;
    logic [IW-1:0] o_id;
    logic          i_ready;
`ifdef ARB_WEIGHT_EN
    logic [3:0]    i_weight [N];

    modport master (
        output i_valid, i_last, i_data, i_ready, i_weight,
        input  o_ready, o_valid, o_last, o_data, o_id
    );

    modport slave (
        input  i_valid, i_last, i_data, i_ready, i_weight,
        output o_ready, o_valid, o_last, o_data, o_id
    );
`else
    modport master (
        output i_valid, i_last, i_data, i_ready,
        input  o_ready, o_valid, o_last, o_data, o_id
    );

    modport slave (
        input  i_valid, i_last, i_data, i_ready,
        output o_ready, o_valid, o_last, o_data, o_id
    );
`endif
endinterface

// File: rtl/arb_rr_pkt_stream.sv
// Packet-level round-robin arbiter: one requester owns the merged stream from first beat to last.
// Optional ARB_WEIGHT_EN lets a winner keep the grant for up to i_weight back-to-back packets.
module arb_rr_pkt_stream #(
    parameter int N  = 4,
    parameter int DW = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    arb_rr_pkt_stream_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = IW + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] gnt_q;
    logic [IW-1:0] gnt_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] idle_pick_s;
    logic [IW-1:0] rot_pick_s;
    logic          gnt_valid_s;
    logic          gnt_last_s;
    logic          eop_s;
    logic          keep_s;
`ifdef ARB_WEIGHT_EN
    logic [3:0]    credit_q;
    logic [3:0]    credit_d;
`endif

    // First requester with valid set, searching ptr+1, ptr+2, ... ptr with wrap at N.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] ptr);
        logic [CW-1:0] idx;
        logic [IW-1:0] win;
        win = {IW{1'b0}};
        for (int k = N; k >= 1; k--) begin
            idx = CW'(ptr) + CW'(k);
            if (idx >= CW'(N)) begin
                idx = idx - CW'(N);
            end else begin
                idx = idx;
            end
            if (req[idx[IW-1:0]]) begin
                win = idx[IW-1:0];
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

`ifdef ARB_WEIGHT_EN
    // A weight of zero still grants one packet.
    function automatic logic [3:0] credit_load(input logic [3:0] w);
        return (w == 4'd0) ? 4'd1 : w;
    endfunction
`endif

    assign gnt_valid_s = bus.i_valid[gnt_q];
    assign gnt_last_s  = bus.i_last[gnt_q];
    assign eop_s       = (state_q == ST_GRANT) && gnt_valid_s && gnt_last_s && bus.i_ready;
    assign idle_pick_s = rr_pick(bus.i_valid, ptr_q);
    assign rot_pick_s  = rr_pick(bus.i_valid, gnt_q);
`ifdef ARB_WEIGHT_EN
    assign keep_s      = (credit_q > 4'd1) && gnt_valid_s;
`else
    assign keep_s      = 1'b0;
`endif

    // Next grant, pointer and state; rotation re-arbitrates in the end-of-packet cycle.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
`ifdef ARB_WEIGHT_EN
        credit_d = credit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|bus.i_valid) begin
                    state_d = ST_GRANT;
                    gnt_d   = idle_pick_s;
`ifdef ARB_WEIGHT_EN
                    credit_d = credit_load(bus.i_weight[idle_pick_s]);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (eop_s && keep_s) begin
                    gnt_d = gnt_q;
`ifdef ARB_WEIGHT_EN
                    credit_d = credit_q - 4'd1;
`endif
                end else if (eop_s) begin
                    ptr_d = gnt_q;
                    if (|bus.i_valid) begin
                        state_d = ST_GRANT;
                        gnt_d   = rot_pick_s;
`ifdef ARB_WEIGHT_EN
                        credit_d = credit_load(bus.i_weight[rot_pick_s]);
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = {IW{1'b0}};
            end
        endcase
    end

    // Arbiter state; reset drops the grant at once, aborting any packet in flight.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= {IW{1'b0}};
            ptr_q   <= IW'(N - 1);
`ifdef ARB_WEIGHT_EN
            credit_q <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
`ifdef ARB_WEIGHT_EN
            credit_q <= credit_d;
`endif
        end
    end

    // Merged stream: a pass-through of the granted requester, all zero without a grant.
    always_comb begin
        bus.o_valid = 1'b0;
        bus.o_last  = 1'b0;
        bus.o_data  = {DW{1'b0}};
        bus.o_id    = {IW{1'b0}};
        bus.o_ready = {N{1'b0}};
        if (state_q == ST_GRANT) begin
            bus.o_valid        = gnt_valid_s;
            bus.o_last         = gnt_last_s;
            bus.o_data         = bus.i_data[gnt_q];
            bus.o_id           = gnt_q;
            bus.o_ready[gnt_q] = bus.i_ready;
        end else begin
            bus.o_valid = 1'b0;
            bus.o_ready = {N{1'b0}};
        end
    end
endmodule

// File: tb/tb_arb_rr_pkt_stream.sv
// Bench for arb_rr_pkt_stream: a vector table for cycle-level arbitration, then packet
// sequences whose expected beats are queued as the sources are loaded.
module tb_arb_rr_pkt_stream;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;
    localparam int NV = 12;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct packed {
        logic [N-1:0]  valid;
        logic [N-1:0]  last;
        logic          rdy;
        logic          e_gnt;
        logic          e_valid;
        logic          e_last;
        logic [IW-1:0] e_id;
        logic [N-1:0]  e_ready;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst_n;
    beat_t src_q [N][$];
    exp_t  sb_q [$];
    int    start_cyc [N];
    int    stall_lo;
    int    stall_hi;
    int    cyc;
    int    n_checks;
    int    n_pass;
    vec_t  vt [NV];

    always #5 clk = ~clk;

    arb_rr_pkt_stream_if #(.N(N), .DW(DW)) bus ();

    arb_rr_pkt_stream #(.N(N), .DW(DW)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    function automatic logic [DW-1:0] pat(input int r);
        return DW'(32'hA0F0 + r);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic add_pkt(input int r, input int tag, input int nbeats);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < nbeats; i++) begin
            b.data = {4'(r), 4'(tag), 8'(i)};
            b.last = (i == nbeats - 1);
            src_q[r].push_back(b);
            e.id   = IW'(r);
            e.data = b.data;
            e.last = b.last;
            sb_q.push_back(e);
        end
    endtask

    task automatic drive_inputs();
        for (int r = 0; r < N; r++) begin
            if (src_q[r].size() > 0 && cyc >= start_cyc[r]) begin
                bus.i_valid[r] = 1'b1;
                bus.i_data[r]  = src_q[r][0].data;
                bus.i_last[r]  = src_q[r][0].last;
            end else begin
                bus.i_valid[r] = 1'b0;
                bus.i_data[r]  = {DW{1'b0}};
                bus.i_last[r]  = 1'b0;
            end
        end
        bus.i_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    endtask

    task automatic tick();
        logic [N-1:0] took;
        logic [N-1:0] oh;
        exp_t         e;
        @(negedge clk);
        if (bus.o_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL extra_beat: got id %0d data %h, want no beat", bus.o_id, bus.o_data);
            end else begin
                e  = sb_q[0];
                oh = {N{1'b0}};
                if (bus.i_ready) oh[e.id] = 1'b1;
                check($sformatf("beat_c%0d", cyc), {bus.o_id, bus.o_data, bus.o_last, bus.o_ready},
                      {e.id, e.data, e.last, oh});
                if (bus.i_ready) void'(sb_q.pop_front());
            end
        end
        took = bus.o_ready & bus.i_valid;
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) begin
            if (took[r]) void'(src_q[r].pop_front());
        end
        cyc++;
        drive_inputs();
    endtask

    task automatic run_seq(input string name, input int exp_cycles);
        int n;
        n   = 0;
        cyc = 1;
        drive_inputs();
        while (sb_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        check({name, "_cycles"}, 64'(n), 64'(exp_cycles));
        check({name, "_drained"}, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic clear_env();
        for (int r = 0; r < N; r++) begin
            src_q[r].delete();
            start_cyc[r]   = 0;
            bus.i_valid[r] = 1'b0;
            bus.i_last[r]  = 1'b0;
            bus.i_data[r]  = {DW{1'b0}};
        end
        sb_q.delete();
        stall_lo    = 1000;
        stall_hi    = 0;
        bus.i_ready = 1'b0;
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        for (int r = 0; r < N; r++) bus.i_data[r] = pat(r);
        bus.i_valid = 4'b1111;
        bus.i_last  = 4'b1111;
        bus.i_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check({name, "_rst_out"}, {bus.o_valid, bus.o_last, bus.o_id, bus.o_data, bus.o_ready}, 64'd0);
        @(posedge clk);
        #1;
        check({name, "_rst_hold"}, {bus.o_valid, bus.o_last, bus.o_id, bus.o_data, bus.o_ready}, 64'd0);
        clear_env();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_data;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        cyc      = 0;
        clear_env();
`ifdef ARB_WEIGHT_EN
        for (int r = 0; r < N; r++) bus.i_weight[r] = 4'd1;
`endif
        // valid, last, rdy | grant, o_valid, o_last, o_id, o_ready
        vt[0]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        vt[1]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001};
        vt[2]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010};
        vt[3]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
        vt[4]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000};
        vt[5]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001};
        vt[6]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010};
        vt[7]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010};
        vt[8]  = '{4'b0110, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010};
        vt[9]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0100};
        vt[10] = '{4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0000};
        vt[11] = '{4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};

        do_reset("t1");
        for (int i = 0; i < NV; i++) begin
            bus.i_valid = vt[i].valid;
            bus.i_last  = vt[i].last;
            bus.i_ready = vt[i].rdy;
            for (int r = 0; r < N; r++) bus.i_data[r] = pat(r);
            @(negedge clk);
            exp_data = vt[i].e_gnt ? pat(int'(vt[i].e_id)) : {DW{1'b0}};
            check($sformatf("vec%0d", i), {bus.o_valid, bus.o_last, bus.o_id, bus.o_data, bus.o_ready},
                  {vt[i].e_valid, vt[i].e_last, vt[i].e_id, exp_data, vt[i].e_ready});
            @(posedge clk);
            #1;
        end

        // Req1 three beats with req2 waiting: no idle cycle between the packets.
        do_reset("t2");
        add_pkt(1, 1, 3);
        add_pkt(2, 2, 2);
        run_seq("t2", 6);

        // Five stalled cycles inside req0's packet.
        do_reset("t3");
        stall_lo = 4;
        stall_hi = 8;
        add_pkt(0, 3, 4);
        add_pkt(1, 4, 1);
        run_seq("t3", 11);

        // Sole requester 3 back to back, then req0 and req2 arrive on its last beat.
        do_reset("t4");
        add_pkt(3, 5, 2);
        add_pkt(3, 6, 1);
        add_pkt(3, 7, 2);
        start_cyc[0] = 6;
        start_cyc[2] = 6;
        add_pkt(0, 8, 1);
        add_pkt(2, 9, 1);
        run_seq("t4", 8);

        // Reset during beat 2 of a 4-beat packet.
        do_reset("t5");
        add_pkt(2, 10, 4);
        cyc = 1;
        drive_inputs();
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        check("t5_beat2", {bus.o_valid, bus.o_id, bus.o_data, 8'(sb_q.size())},
              {1'b1, 2'd2, {4'd2, 4'd10, 8'd2}, 8'd2});
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_abort", {bus.o_valid, bus.o_last, bus.o_id, bus.o_data, bus.o_ready}, 64'd0);
        clear_env();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        add_pkt(0, 11, 1);
        add_pkt(2, 12, 1);
        run_seq("t5_after", 3);

`ifdef ARB_WEIGHT_EN
        // Weights {1,3,0,1}: req1 keeps three packets, weight 0 acts as 1.
        do_reset("t6");
        bus.i_weight[0] = 4'd1;
        bus.i_weight[1] = 4'd3;
        bus.i_weight[2] = 4'd0;
        bus.i_weight[3] = 4'd1;
        add_pkt(0, 1, 1);
        add_pkt(1, 2, 1);
        add_pkt(1, 3, 1);
        add_pkt(1, 4, 1);
        add_pkt(2, 5, 1);
        add_pkt(3, 6, 1);
        add_pkt(0, 7, 1);
        add_pkt(2, 8, 1);
        run_seq("t6", 9);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
